// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
// Types and constants shared by the RAM port arbiter.
//   state_e     : arbiter mode. CLEAR zero-fills the RAM and RUN arbitrates the two ports.
//   STARVE_W    : width of the anti-starvation counter. It holds values up to 255.
//   byte_lanes(): number of byte write-enable lanes in a data word.
package ram_port_arbiter_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam int STARVE_W = 8;

   function automatic int byte_lanes(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Connects an instruction-fetch port (I) and a load/store port (D) to one
// single-port, byte-enabled RAM. The RAM has registered read data.
// After reset the arbiter can zero-fill the whole RAM. It then arbitrates
// every cycle. D has priority. After MAX_DATA_BURST back-to-back D grants
// while I waits, I is forced through.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   init_done                  : high in the RUN state
//   i_req/i_addr               : fetch read request
//   i_gnt/i_rvalid/i_rdata     : fetch grant, read-data valid, read data
//   d_req/d_addr/d_we/d_wdata  : data request (d_we all-zero means read)
//   d_gnt/d_rvalid/d_rdata     : data grant, read-data valid, read data
//   ram_addr/ram_din/ram_write_en/ram_dout : RAM macro interface
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH     = 14,
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_DATA_BURST = 4,
   parameter int INIT_CLEAR     = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic                    init_done,
   input  logic                    i_req,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic                    i_gnt,
   output logic                    i_rvalid,
   output logic [DATA_WIDTH-1:0]   i_rdata,
   input  logic                    d_req,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH/8-1:0] d_we,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic [DATA_WIDTH-1:0]   ram_din,
   output logic [DATA_WIDTH/8-1:0] ram_write_en,
   input  logic [DATA_WIDTH-1:0]   ram_dout
);

   localparam int LANES = byte_lanes(DATA_WIDTH);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_DATA_BURST);
   localparam state_e RESET_STATE = (INIT_CLEAR != 0) ? CLEAR : RUN;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
   logic [STARVE_W-1:0]     starve_q, starve_d;
   logic                    i_rvalid_q, i_rvalid_d;
   logic                    d_rvalid_q, d_rvalid_d;

   // Mode sequencing, arbitration and RAM drive.
   // The RAM returns data one cycle after the address. Both read-data outputs
   // therefore come straight from ram_dout, and the valids are registered grants.
   // Reset masks every grant and write enable in the same cycle. A RAM write
   // can never slip through while reset is being applied.
   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      starve_d     = starve_q;
      i_gnt        = 1'b0;
      d_gnt        = 1'b0;
      init_done    = 1'b0;
      ram_addr     = i_addr;
      ram_din      = d_wdata;
      ram_write_en = '0;

      case (state_q)
         CLEAR: begin
            ram_addr     = clr_cnt_q;
            ram_din      = '0;
            ram_write_en = {LANES{1'b1}};
            clr_cnt_d    = clr_cnt_q + 1'b1;
            starve_d     = '0;
            if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
               state_d = RUN;
            end
         end
         RUN: begin
            init_done = 1'b1;
            // D wins a tie unless I has already waited out a full data burst.
            if (d_req && !(i_req && (starve_q == STARVE_MAX))) begin
               d_gnt = 1'b1;
            end else if (i_req) begin
               i_gnt = 1'b1;
            end
            if (d_gnt) begin
               ram_addr     = d_addr;
               ram_write_en = d_we;
            end
            // The counter measures only an unbroken wait by I. A cycle without
            // an I request, or an I grant, ends the wait.
            if (!i_req || i_gnt) begin
               starve_d = '0;
            end else if (d_gnt && (starve_q != STARVE_MAX)) begin
               starve_d = starve_q + 1'b1;
            end
         end
         default: begin
            state_d = RESET_STATE;
         end
      endcase

      if (reset) begin
         i_gnt        = 1'b0;
         d_gnt        = 1'b0;
         init_done    = 1'b0;
         ram_write_en = '0;
      end

      i_rvalid_d = i_gnt;
      d_rvalid_d = d_gnt && (d_we == '0);
   end

   // State registers. Reset drops any read in flight so no stale rvalid appears.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RESET_STATE;
         clr_cnt_q  <= '0;
         starve_q   <= '0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         starve_q   <= starve_d;
         i_rvalid_q <= i_rvalid_d;
         d_rvalid_q <= d_rvalid_d;
      end
   end

   assign i_rvalid = i_rvalid_q && !reset;
   assign d_rvalid = d_rvalid_q && !reset;
   assign i_rdata  = ram_dout;
   assign d_rdata  = ram_dout;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port, byte-enabled, synchronous-read RAM between two requesters: instruction fetch (I) and load/store data (D).
- Optionally clears the whole RAM to zero after reset.
- Data port has fixed priority, bounded by an anti-starvation counter so fetch always progresses.
- Sits between the core's fetch/LSU units and the RAM instance.

Parameters:
ADDR_WIDTH, 14, word-address width of the RAM (depth = 2^ADDR_WIDTH words)
DATA_WIDTH, 32, RAM word width; multiple of 8
MAX_DATA_BURST, 4, max consecutive D grants while I is waiting; range 1..255
INIT_CLEAR, 1, 1 = zero-fill RAM after reset; 0 = go straight to RUN

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
init_done  out  1  high when in RUN state
i_req  in  1  fetch read request
i_addr  in  ADDR_WIDTH  fetch word address
i_gnt  out  1  fetch request accepted this cycle
i_rvalid  out  1  i_rdata valid (one cycle after i_gnt)
i_rdata  out  DATA_WIDTH  fetch read data
d_req  in  1  data request
d_addr  in  ADDR_WIDTH  data word address
d_we  in  DATA_WIDTH/8  byte write enables; all-zero = read
d_wdata  in  DATA_WIDTH  write data, lane-aligned
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  d_rdata valid (one cycle after a read d_gnt)
d_rdata  out  DATA_WIDTH  data read data
ram_addr  out  ADDR_WIDTH  RAM address
ram_din  out  DATA_WIDTH  RAM write data
ram_write_en  out  DATA_WIDTH/8  RAM byte write enables
ram_dout  in  DATA_WIDTH  RAM registered read data

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high. While reset is high:
  - i_gnt, d_gnt, i_rvalid, d_rvalid, init_done = 0.
  - Clear counter = 0; starvation counter = 0.
  - State = CLEAR if INIT_CLEAR=1, else RUN.
  - ram_write_en = 0.
- FSM: CLEAR -> RUN when the clear counter reaches 2^ADDR_WIDTH-1; RUN is terminal until reset.
  - A reset asserted mid-operation, including mid-CLEAR, restarts from this reset state on the next edge.
  - Any read in flight at that point is dropped: no rvalid is produced.
- CLEAR state:
  - ram_addr = clear counter; ram_din = 0; ram_write_en = all ones.
  - Counter increments by 1 per cycle.
  - Both grants = 0; requests are ignored, not queued. Requesters hold req until granted.
  - Takes exactly 2^ADDR_WIDTH cycles. init_done rises in the first RUN cycle.
- RUN arbitration (combinational, same cycle as req):
  - Only D requesting -> d_gnt.
  - Only I requesting -> i_gnt.
  - Both requesting -> d_gnt, unless starvation counter == MAX_DATA_BURST; then i_gnt.
  - Neither requesting -> no grant.
  - At most one grant per cycle.
- Starvation counter:
  - Increments when d_gnt=1 and i_req=1.
  - Clears to 0 on any i_gnt, or on any cycle with i_req=0.
  - Saturates at MAX_DATA_BURST.
- RAM drive in RUN:
  - ram_addr = d_addr if d_gnt, else i_addr (also when idle).
  - ram_din = d_wdata.
  - ram_write_en = d_we if d_gnt, else 0.
- Read return:
  - i_rvalid(t+1) = i_gnt(t).
  - d_rvalid(t+1) = d_gnt(t) and d_we(t)==0.
  - Data writes produce no rvalid.
  - i_rdata and d_rdata are both wired directly to ram_dout; each is meaningful only while its rvalid is high.
- Back-to-back: one access per cycle, full throughput. A write followed by a read of the same address on the next cycle returns the new data (RAM ordering).
- Partial write (some d_we bits set): only the enabled byte lanes change.

Decomposition:
- Shared package `ram_port_arbiter_pkg`:
  - State enum {CLEAR, RUN}.
  - Constant for byte-lane count (DATA_WIDTH/8).
  - Starvation-counter width (8 bits).
- No sub-module is needed; the clear sequencer and arbiter fit in one module.
- The bench instantiates the byte-enabled simulation RAM model as the RAM.

Test Plan:
- Clear: ADDR_WIDTH=4, INIT_CLEAR=1, RAM preloaded with 0xFFFFFFFF; release reset -> 16 cycles of all-ones write_en at addresses 0..15; init_done rises on cycle 16; I read of addr 7 returns 0x00000000.
- Contention: MAX_DATA_BURST=4; i_req and d_req held high, D reads -> grant pattern D,D,D,D,I,D,D,D,D,I...; each rvalid arrives exactly one cycle after its grant.
- Byte write: D write addr 3, d_we=4'b0010, d_wdata=0x0000AB00 over 0x11223344; then D read addr 3 -> d_rdata=0x1122AB44; d_rvalid is high only for the read.
- Write-then-read: D write addr 5 =0xDEADBEEF at cycle t; I read addr 5 at t+1 -> i_rdata=0xDEADBEEF at t+2.
- Reset mid-CLEAR: assert reset at clear count 9 -> no grants or rvalids; counter restarts at 0 and CLEAR takes a full 16 cycles after release.
- Reset mid-read: i_gnt at t, reset at t+1 -> i_rvalid=0 at t+1 and t+2.
